input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer_pkg.sv | 20 ++
 rtl/input_debouncer_sync_chain.sv | 24 ++
 rtl/input_debouncer.sv | 110 +++++++++++
 tb/tb_input_debouncer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared types and defaults for the input debouncer.
// This includes the FSM state encoding and a saturating increment for the glitch counter.
package input_debouncer_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 4;
  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam logic [7:0] GLITCH_MAX    = 8'hFF;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_CHK_HIGH = 2'd1,
    S_HIGH     = 2'd2,
    S_CHK_LOW  = 2'd3
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == GLITCH_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchronizer that brings an asynchronous level into the clk domain.
// It resets to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw pin level: synchronize, then require STABLE_CYCLES matching samples
// before dout follows. Rejected candidates are counted in a saturating counter.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       dout,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit FAST = (STABLE_CYCLES == 1);

  logic             din_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic [7:0]       glitch_q, glitch_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (din_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOW;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  // With a single required sample the change is accepted on entry to a CHK state,
  // so a CHK state then only decides whether the input stayed or flipped again.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    glitch_d = glitch_q;
    case (state_q)
      S_LOW: begin
        if (din_s) begin
          state_d = S_CHK_HIGH;
          cnt_d   = CNT_ONE;
          if (FAST) dout_d = 1'b1;
        end
      end
      S_HIGH: begin
        if (!din_s) begin
          state_d = S_CHK_LOW;
          cnt_d   = CNT_ONE;
          if (FAST) dout_d = 1'b0;
        end
      end
      S_CHK_HIGH, S_CHK_LOW: begin
        if (FAST) begin
          if (din_s == dout_q) begin
            state_d = dout_q ? S_HIGH : S_LOW;
            cnt_d   = '0;
          end else begin
            state_d = din_s ? S_CHK_HIGH : S_CHK_LOW;
            cnt_d   = CNT_ONE;
            dout_d  = din_s;
          end
        end else if (din_s == dout_q) begin
          state_d  = (state_q == S_CHK_HIGH) ? S_LOW : S_HIGH;
          cnt_d    = '0;
          glitch_d = sat_inc8(glitch_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d = (state_q == S_CHK_HIGH) ? S_HIGH : S_LOW;
          cnt_d   = '0;
          dout_d  = ~dout_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == S_CHK_HIGH) || (state_d == S_CHK_LOW);
  end

  assign dout       = dout_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: one default instance and one with STABLE_CYCLES=1, SYNC_STAGES=3.
// Each check compares against hand-computed edge counts.
module tb_input_debouncer;

  logic       clk;
  logic       rst;
  logic       din;
  logic       dout;
  logic       busy;
  logic [7:0] glitchCnt;
  logic       din2;
  logic       dout2;
  logic       busy2;
  logic [7:0] glitchCnt2;

  int checkCount = 0;
  int errorCount = 0;
  int riseCount  = 0;
  int fallCount  = 0;
  int riseCount2 = 0;
  int riseBase;
  int fallBase;

  input_debouncer dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .dout      (dout),
    .busy      (busy),
    .glitch_cnt(glitchCnt)
  );

  input_debouncer #(
    .STABLE_CYCLES(1),
    .SYNC_STAGES  (3)
  ) dutFast (
    .clk       (clk),
    .rst       (rst),
    .din       (din2),
    .dout      (dout2),
    .busy      (busy2),
    .glitch_cnt(glitchCnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge monitors stand in for the downstream edge detector.
  always @(posedge dout)  riseCount++;
  always @(negedge dout)  fallCount++;
  always @(posedge dout2) riseCount2++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic level);
    din = level;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    din  = 1'b0;
    din2 = 1'b0;

    // Reset window with din toggling.
    #2 applyStimulus(1'b1);
    #2;
    checkOutput("rst_dout_t4", dout, 0);
    checkOutput("rst_busy_t4", busy, 0);
    #4 applyStimulus(1'b0);
    #1;
    checkOutput("rst_dout_t9", dout, 0);
    checkOutput("rst_busy_t9", busy, 0);
    checkOutput("rst_glitch_t9", glitchCnt, 0);
    checkOutput("rst_dout2_t9", dout2, 0);
    #3 rst = 1'b0;

    // Rising edge: din set before the 15 ns edge.
    #2 applyStimulus(1'b1);
    #2;
    checkOutput("rise_busy_16", busy, 0);
    waitEdges(1);
    checkOutput("rise_busy_26", busy, 0);
    waitEdges(1);
    checkOutput("rise_busy_36", busy, 1);
    waitEdges(2);
    checkOutput("rise_dout_56", dout, 0);
    checkOutput("rise_busy_56", busy, 1);
    waitEdges(1);
    checkOutput("rise_dout_66", dout, 1);
    checkOutput("rise_busy_66", busy, 0);

    // Two-sample low glitch while high.
    fallBase = fallCount;
    applyStimulus(1'b0);
    waitEdges(2);
    applyStimulus(1'b1);
    waitEdges(6);
    checkOutput("lowglitch_dout", dout, 1);
    checkOutput("lowglitch_cnt", glitchCnt, 1);
    checkOutput("lowglitch_falls", fallCount - fallBase, 0);

    // Qualified fall: same 6-edge latency, exactly one falling edge.
    fallBase = fallCount;
    applyStimulus(1'b0);
    waitEdges(5);
    checkOutput("fall_dout_k4", dout, 1);
    waitEdges(1);
    checkOutput("fall_dout_k5", dout, 0);
    checkOutput("fall_busy_k5", busy, 0);
    waitEdges(3);
    checkOutput("fall_count", fallCount - fallBase, 1);

    // Three-sample high pulse is rejected.
    riseBase = riseCount;
    applyStimulus(1'b1);
    waitEdges(3);
    applyStimulus(1'b0);
    waitEdges(8);
    checkOutput("pulse3_dout", dout, 0);
    checkOutput("pulse3_glitch", glitchCnt, 2);
    checkOutput("pulse3_rises", riseCount - riseBase, 0);

    // Four-sample pulse is exactly enough to be accepted.
    riseBase = riseCount;
    applyStimulus(1'b1);
    waitEdges(4);
    applyStimulus(1'b0);
    waitEdges(2);
    checkOutput("pulse4_dout_high", dout, 1);
    waitEdges(6);
    checkOutput("pulse4_dout_low", dout, 0);
    checkOutput("pulse4_rises", riseCount - riseBase, 1);
    checkOutput("pulse4_glitch", glitchCnt, 2);

    // Reset during the third cycle of S_CHK_HIGH, then release with din held high.
    applyStimulus(1'b1);
    waitEdges(5);
    checkOutput("midq_busy", busy, 1);
    checkOutput("midq_dout", dout, 0);
    rst = 1'b1;
    #1;
    checkOutput("midq_rst_dout", dout, 0);
    checkOutput("midq_rst_busy", busy, 0);
    checkOutput("midq_rst_glitch", glitchCnt, 0);
    #2 rst = 1'b0;
    waitEdges(5);
    checkOutput("postrst_dout_k4", dout, 0);
    waitEdges(1);
    checkOutput("postrst_dout_k5", dout, 1);
    checkOutput("postrst_glitch", glitchCnt, 0);

    // Return low, then saturate the glitch counter with 300 short pulses.
    applyStimulus(1'b0);
    waitEdges(10);
    checkOutput("sat_start_dout", dout, 0);
    riseBase = riseCount;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1);
      waitEdges(3);
      applyStimulus(1'b0);
      waitEdges(5);
      if (i == 0)   checkOutput("sat_first", glitchCnt, 1);
      if (i == 254) checkOutput("sat_255", glitchCnt, 255);
    end
    checkOutput("sat_final", glitchCnt, 255);
    checkOutput("sat_dout", dout, 0);
    checkOutput("sat_rises", riseCount - riseBase, 0);

    // STABLE_CYCLES=1, SYNC_STAGES=3: single-cycle pulse gives a one-cycle dout pulse 3 edges later.
    riseBase = riseCount2;
    din2 = 1'b1;
    waitEdges(1);
    din2 = 1'b0;
    waitEdges(2);
    checkOutput("fast_dout_k2", dout2, 0);
    waitEdges(1);
    checkOutput("fast_dout_k3", dout2, 1);
    checkOutput("fast_busy_k3", busy2, 1);
    waitEdges(1);
    checkOutput("fast_dout_k4", dout2, 0);
    waitEdges(3);
    checkOutput("fast_dout_settled", dout2, 0);
    checkOutput("fast_busy_settled", busy2, 0);
    checkOutput("fast_glitch", glitchCnt2, 0);
    checkOutput("fast_rises", riseCount2 - riseBase, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
